// File: rtl/seg_display_if.sv
// Connection between the ALU result and the seven-segment display stage.
// The ALU side is the master; the display stage is the slave.
interface seg_display_if;
  logic [7:0] value;
  logic       dec_mode;
  logic       sgn_mode;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;

  modport master (output value, dec_mode, sgn_mode, input seg, an, busy);
  modport slave  (input value, dec_mode, sgn_mode, output seg, an, busy);
endinterface

// File: rtl/seg_display.sv
// Basys3 4-digit seven-segment driver for the 8-bit ALU result: hex or decimal
// rendering via sequential double-dabble, time-multiplexed at REFRESH_DIV cycles per digit.
module seg_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic         clk,
  input  logic         reset,
  seg_display_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] LOAD    = 2'd2;

  // Display registers hold a 5-bit code: 0..15 glyph, plus blank and minus.
  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CODE_MINUS = 5'd17;

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [1:0]       state;
  logic [7:0]       snap_value;
  logic             snap_dec;
  logic             snap_sgn;
  logic [7:0]       bin;
  logic [11:0]      bcd;
  logic [2:0]       iter;
  logic [3:0][4:0]  disp;
  logic [3:0][4:0]  disp_next;
  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_idx;

  logic             mismatch;
  logic [8:0]       magnitude;
  logic [11:0]      bcd_adj;
  logic             negative;

  assign mismatch  = {bus.value, bus.dec_mode, bus.sgn_mode} != {snap_value, snap_dec, snap_sgn};
  assign magnitude = (bus.sgn_mode && bus.value[7]) ? 9'd256 - {1'b0, bus.value}
                                                    : {1'b0, bus.value};
  assign negative  = snap_sgn && snap_value[7];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    disp_next = {CODE_BLANK, CODE_BLANK, 1'b0, snap_value[7:4], 1'b0, snap_value[3:0]};
    if (snap_dec) begin
      disp_next[3] = negative ? CODE_MINUS : CODE_BLANK;
      disp_next[2] = (bcd[11:8] == 4'd0) ? CODE_BLANK : {1'b0, bcd[11:8]};
      disp_next[1] = (bcd[11:4] == 8'd0) ? CODE_BLANK : {1'b0, bcd[7:4]};
      disp_next[0] = {1'b0, bcd[3:0]};
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      snap_value <= 8'd0;
      snap_dec   <= 1'b0;
      snap_sgn   <= 1'b0;
      bin        <= 8'd0;
      bcd        <= 12'd0;
      iter       <= 3'd0;
      disp       <= {CODE_BLANK, CODE_BLANK, 5'd0, 5'd0};
    end else begin
      case (state)
        IDLE: begin
          if (mismatch) begin
            snap_value <= bus.value;
            snap_dec   <= bus.dec_mode;
            snap_sgn   <= bus.sgn_mode;
            bin        <= magnitude[7:0];
            bcd        <= 12'd0;
            iter       <= 3'd0;
            state      <= bus.dec_mode ? CONVERT : LOAD;
          end
        end
        CONVERT: begin
          {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
          iter       <= iter + 3'd1;
          if (iter == 3'd7) state <= LOAD;
        end
        LOAD: begin
          disp  <= disp_next;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
    end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  function automatic logic [6:0] glyph(input logic [4:0] code);
    case (code)
      5'd0:    glyph = 7'b1000000;
      5'd1:    glyph = 7'b1111001;
      5'd2:    glyph = 7'b0100100;
      5'd3:    glyph = 7'b0110000;
      5'd4:    glyph = 7'b0011001;
      5'd5:    glyph = 7'b0010010;
      5'd6:    glyph = 7'b0000010;
      5'd7:    glyph = 7'b1111000;
      5'd8:    glyph = 7'b0000000;
      5'd9:    glyph = 7'b0010000;
      5'd10:   glyph = 7'b0001000;
      5'd11:   glyph = 7'b0000011;
      5'd12:   glyph = 7'b1000110;
      5'd13:   glyph = 7'b0100001;
      5'd14:   glyph = 7'b0000110;
      5'd15:   glyph = 7'b0001110;
      5'd17:   glyph = 7'b0111111;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  assign bus.an   = ~(4'b0001 << digit_idx);
  assign bus.seg  = glyph(disp[digit_idx]);
  assign bus.busy = (state == CONVERT) || (state == LOAD);

endmodule

// File: tb/tb_seg_display.sv
// Scoreboard bench for seg_display: expected digits are queued when a value is
// driven and compared against the multiplexed display once busy drops.
module tb_seg_display;

  localparam int REFRESH_DIV = 4;
  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_MINUS = 7'b0111111;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [27:0] sb_q[$];

  seg_display_if bus ();

  seg_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph7(input int n);
    case (n)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0001000;
      11: return 7'b0000011;
      12: return 7'b1000110;
      13: return 7'b0100001;
      14: return 7'b0000110;
      15: return 7'b0001110;
      default: return 7'b1010101;
    endcase
  endfunction

  // Expected glyphs {digit3, digit2, digit1, digit0}.
  function automatic logic [27:0] model(input logic [7:0] v, input logic d, input logic s);
    logic [6:0] dg [4];
    int mag, h, t, o;
    logic neg;
    if (!d) begin
      dg[3] = G_BLANK;
      dg[2] = G_BLANK;
      dg[1] = glyph7(int'(v[7:4]));
      dg[0] = glyph7(int'(v[3:0]));
    end else begin
      neg = s && v[7];
      mag = neg ? 256 - int'(v) : int'(v);
      h = mag / 100;
      t = (mag / 10) % 10;
      o = mag % 10;
      dg[3] = neg ? G_MINUS : G_BLANK;
      dg[2] = (h == 0) ? G_BLANK : glyph7(h);
      dg[1] = (h == 0 && t == 0) ? G_BLANK : glyph7(t);
      dg[0] = glyph7(o);
    end
    return {dg[3], dg[2], dg[1], dg[0]};
  endfunction

  function automatic int an_index(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic drive_push(input logic [7:0] v, input logic d, input logic s);
    bus.value    = v;
    bus.dec_mode = d;
    bus.sgn_mode = s;
    sb_q.push_back(model(v, d, s));
  endtask

  task automatic wait_busy(input logic level, input int budget, input string tag);
    int n = 0;
    while (bus.busy !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, bus.busy}, {31'd0, level});
  endtask

  // Watch the multiplexed outputs long enough to see every digit at least once.
  task automatic scan_compare(input string tag, input logic [27:0] exp);
    logic [7:0] cap [4];
    logic [3:0] prev_an;
    int run = 0, bad_dwell = 0, bad_onehot = 0, idx;
    logic first_run = 1'b1;
    for (int i = 0; i < 4; i++) cap[i] = 8'hFF;
    prev_an = bus.an;
    for (int s = 0; s < 6 * REFRESH_DIV; s++) begin
      idx = an_index(bus.an);
      if (idx < 0) bad_onehot++;
      else cap[idx] = {1'b0, bus.seg};
      if (bus.an == prev_an) run++;
      else begin
        if (!first_run && run != REFRESH_DIV) bad_dwell++;
        first_run = 1'b0;
        run = 1;
      end
      prev_an = bus.an;
      @(negedge clk);
    end
    check({tag, "_onehot"}, bad_onehot, 0);
    check({tag, "_dwell"}, bad_dwell, 0);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_digit%0d", tag, i), {24'd0, cap[i]}, {25'd0, exp[i*7 +: 7]});
  endtask

  task automatic expect_txn(input int exp_busy, input string tag);
    int n = 0;
    logic [27:0] exp;
    wait_busy(1'b1, 20, {tag, "_busy_rise"});
    while (bus.busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, n, exp_busy);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      exp = sb_q.pop_front();
      scan_compare(tag, exp);
    end
  endtask

  task automatic run_txn(input logic [7:0] v, input logic d, input logic s,
                         input int exp_busy, input string tag);
    drive_push(v, d, s);
    expect_txn(exp_busy, tag);
  endtask

  initial begin
    int busy_seen, bad, n, idx;
    logic rose;
    logic [27:0] exp16, exp32;

    reset = 1'b1;
    bus.value = 8'h00;
    bus.dec_mode = 1'b0;
    bus.sgn_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_an", bus.an, 4'b1110);
    check("reset_seg", bus.seg, 7'b1000000);
    check("reset_busy", bus.busy, 0);
    reset = 1'b0;

    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
    end
    check("idle_no_busy", busy_seen, 0);

    run_txn(8'hA5, 1'b0, 1'b0, 1, "hex_a5");
    run_txn(8'd200, 1'b1, 1'b0, 9, "dec_200");
    run_txn(8'd7, 1'b1, 1'b0, 9, "dec_7");
    run_txn(8'h80, 1'b1, 1'b1, 9, "sgn_80");
    run_txn(8'hFF, 1'b1, 1'b1, 9, "sgn_ff");
    run_txn(8'h7F, 1'b1, 1'b1, 9, "sgn_7f");
    run_txn(8'hFF, 1'b0, 1'b1, 1, "hex_ff");

    // Change the input on the third CONVERT cycle: old result first, then the new one.
    drive_push(8'h10, 1'b1, 1'b0);
    wait_busy(1'b1, 20, "mid_busy_rise");
    repeat (2) @(negedge clk);
    drive_push(8'h20, 1'b1, 1'b0);
    wait_busy(1'b0, 20, "mid_busy_fall");
    exp16 = sb_q.pop_front();
    exp32 = sb_q.pop_front();
    rose = 1'b0;
    bad = 0;
    n = 0;
    while (!(rose && bus.busy === 1'b0) && n < 40) begin
      idx = an_index(bus.an);
      if (idx < 0 || bus.seg !== exp16[idx*7 +: 7]) bad++;
      if (bus.busy === 1'b1) rose = 1'b1;
      @(negedge clk);
      n++;
    end
    check("mid_second_window", rose, 1);
    check("mid_hold_16", bad, 0);
    scan_compare("mid_32", exp32);

    // Reset in the middle of a conversion aborts it.
    drive_push(8'h99, 1'b1, 1'b0);
    void'(sb_q.pop_back());
    wait_busy(1'b1, 20, "rst_busy_rise");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_an", bus.an, 4'b1110);
    check("rst_mid_seg", bus.seg, 7'b1000000);
    check("rst_mid_busy", bus.busy, 0);
    @(negedge clk);
    drive_push(8'h42, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    expect_txn(1, "post_rst_42");

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
